crc_transmitter: RTL

- Upstream partner of the CRC receiving stage.
- Accepts a BW-bit data word over a valid/ready handshake and computes its CRC_BW-bit CRC bit-serially with an LFSR, MSB first.
- Presents the codeword {data, crc} on a registered output with a valid/ready handshake.
- An optional single-bit error injection lets the downstream checker be exercised in-system.

---
 rtl/crc_transmitter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/crc_transmitter.sv
// Bit-serial CRC encoder: accepts a data word, shifts it MSB-first through an LFSR,
// then presents {data, crc} on a registered valid/ready output.
module crc_transmitter #(
    parameter int              BW      = 4,
    parameter int              CRC_BW  = 3,
    parameter logic [CRC_BW:0] divisor = 4'b1011
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BW-1:0]        in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 err_inj,
    output logic [BW+CRC_BW-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           tx_count
);

    localparam int CW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         data_q, data_d;
    logic [BW-1:0]         shift_q, shift_d;
    logic [CRC_BW-1:0]     crc_q, crc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [BW+CRC_BW-1:0]  out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [7:0]            tx_count_q, tx_count_d;

    logic                  fb;
    logic                  last_bit;
    logic [CRC_BW-1:0]     crc_step;

    // One LFSR step with the current data bit; the implicit x^CRC_BW term is dropped.
    always_comb begin
        fb       = shift_q[BW-1] ^ crc_q[CRC_BW-1];
        crc_step = (crc_q << 1) ^ (fb ? divisor[CRC_BW-1:0] : '0);
        last_bit = (cnt_q == CW'(BW - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            shift_q     <= '0;
            crc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            tx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            tx_count_q  <= tx_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (last_bit)  state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        tx_count_d  = tx_count_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in;
                    shift_d = in;
                    err_d   = err_inj;
                    crc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                crc_d   = crc_step;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    out_d       = {data_q, crc_step ^ CRC_BW'(err_q)};
                    out_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    tx_count_d  = tx_count_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out       = out_q;
        out_valid = out_valid_q;
        tx_count  = tx_count_q;
    end

endmodule
